axis_stream_sink: RTL

//  Synthesizable AXI4-Stream receiver (slave end) that terminates a stream driven by the stream VIP master or DUT.
//  - Generates a programmable tready backpressure pattern.
//  - Accepts beats and reports per-packet beat/byte counts, a checksum, TID/TDEST and errors.
//  - Used as the far-end sink in stream testbenches and on-board loopback checks.

---
 rtl/axis_sink_pkg.sv | 27 ++
 rtl/axis_stream_sink_if.sv | 21 ++
 rtl/axis_sink_ready_gen.sv | 21 ++
 rtl/axis_stream_sink.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/axis_sink_pkg.sv
// Shared types and helpers for the AXI4-Stream sink.
package axis_sink_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RECV = ST_RECV,
    DROP = ST_DROP
  } sink_state_e;

  typedef struct packed {
    logic tid;
    logic keep;
    logic oversize;
  } pkt_err_t;

  localparam int unsigned KEEP_MAX_W = 128;

  // True when keep is a non-empty run of ones starting at bit 0.
  function automatic logic keep_contiguous(input logic [KEEP_MAX_W-1:0] keep);
    return (keep != '0) && ((keep & (keep + KEEP_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/axis_stream_sink_if.sv
// AXI4-Stream bundle with master/slave views.
interface axis_stream_sink_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned USER_WIDTH = 1
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [BYTES-1:0]      tkeep;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_sink_ready_gen.sv
// Rotating tready pattern generator; pointer advances every enabled cycle.
module axis_sink_ready_gen (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        aclken,
  input  logic        cfg_enable,
  input  logic [15:0] cfg_ready_pattern,
  output logic        tready
);
  logic [3:0] ptr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr    <= '0;
      tready <= 1'b0;
    end else if (aclken) begin
      ptr    <= ptr + 4'd1;
      tready <= cfg_enable & cfg_ready_pattern[ptr];
    end
  end
endmodule

// File: rtl/axis_stream_sink.sv
// AXI4-Stream sink: backpressure pattern, per-packet stats and error flags.
// Optional AXIS_SINK_PROTOCOL_CHECK_EN adds a sticky proto_err output.
module axis_stream_sink
  import axis_sink_pkg::*;
#(
  parameter int unsigned C_AXIS_DATA_WIDTH = 32,
  parameter int unsigned C_AXIS_ID_WIDTH   = 1,
  parameter int unsigned C_AXIS_DEST_WIDTH = 1,
  parameter int unsigned C_AXIS_USER_WIDTH = 1,
  parameter int unsigned C_MAX_PKT_BEATS   = 256
) (
  input  logic                                                   aclk,
  input  logic                                                   aresetn,
  input  logic                                                   aclken,
  input  logic                                                   cfg_enable,
  input  logic [15:0]                                            cfg_ready_pattern,
  axis_stream_sink_if.slave                                      s_axis,
  output logic                                                   pkt_done,
  output logic [$clog2(C_MAX_PKT_BEATS):0]                       pkt_beats,
  output logic [$clog2(C_MAX_PKT_BEATS*(C_AXIS_DATA_WIDTH/8)):0] pkt_bytes,
  output logic [15:0]                                            pkt_checksum,
  output logic [C_AXIS_ID_WIDTH-1:0]                             pkt_id,
  output logic [C_AXIS_DEST_WIDTH-1:0]                           pkt_dest,
  output logic [2:0]                                             pkt_err,
  output logic [31:0]                                            pkt_count
`ifdef AXIS_SINK_PROTOCOL_CHECK_EN
  ,
  output logic                                                   proto_err
`endif
);
  localparam int unsigned BYTES  = C_AXIS_DATA_WIDTH / 8;
  localparam int unsigned BEAT_W = $clog2(C_MAX_PKT_BEATS) + 1;
  localparam int unsigned BYTE_W = $clog2(C_MAX_PKT_BEATS * BYTES) + 1;
  localparam logic [BEAT_W-1:0] MAX_BEATS = BEAT_W'(C_MAX_PKT_BEATS);
  localparam logic [BYTE_W-1:0] MAX_BYTES = BYTE_W'(C_MAX_PKT_BEATS * BYTES);

  sink_state_e                  state, n_state;
  logic [BEAT_W-1:0]            acc_beats, n_beats;
  logic [BYTE_W-1:0]            acc_bytes, n_bytes, beat_bytes, byte_total;
  logic [15:0]                  acc_sum, n_sum, beat_sum;
  pkt_err_t                     acc_err, n_err;
  logic [C_AXIS_ID_WIDTH-1:0]   first_id, n_id;
  logic [C_AXIS_DEST_WIDTH-1:0] first_dest, n_dest;
  logic                         accept, keep_err, over;
  logic [C_AXIS_USER_WIDTH-1:0] unused_tuser;

  assign unused_tuser = s_axis.tuser;

  axis_sink_ready_gen u_ready_gen (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .aclken            (aclken),
    .cfg_enable        (cfg_enable),
    .cfg_ready_pattern (cfg_ready_pattern),
    .tready            (s_axis.tready)
  );

  assign accept = aclken & s_axis.tvalid & s_axis.tready;

  always_comb begin
    beat_sum   = '0;
    beat_bytes = BYTE_W'($countones(s_axis.tkeep));
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (s_axis.tkeep[i]) beat_sum = beat_sum + {8'd0, s_axis.tdata[8*i +: 8]};
    end
    keep_err = s_axis.tlast ? !keep_contiguous(KEEP_MAX_W'(s_axis.tkeep))
                            : (s_axis.tkeep != '1);
  end

  // Next accumulator values assuming the current beat is accepted.
  always_comb begin
    n_beats    = acc_beats;
    n_bytes    = acc_bytes;
    n_sum      = acc_sum;
    n_err      = acc_err;
    n_id       = first_id;
    n_dest     = first_dest;
    byte_total = '0;
    over       = 1'b0;
    if (state == IDLE) begin
      n_beats = BEAT_W'(1);
      n_bytes = beat_bytes;
      n_sum   = beat_sum;
      n_err   = '{tid: 1'b0, keep: keep_err, oversize: 1'b0};
      n_id    = s_axis.tid;
      n_dest  = s_axis.tdest;
    end else begin
      over           = (acc_beats == MAX_BEATS);
      byte_total     = acc_bytes + beat_bytes;
      n_beats        = over ? acc_beats : acc_beats + BEAT_W'(1);
      n_bytes        = (byte_total > MAX_BYTES) ? MAX_BYTES : byte_total;
      n_sum          = acc_sum + beat_sum;
      n_err.tid      = acc_err.tid | (s_axis.tid != first_id) | (s_axis.tdest != first_dest);
      n_err.keep     = acc_err.keep | keep_err;
      n_err.oversize = acc_err.oversize | over;
    end
    if (s_axis.tlast)        n_state = IDLE;
    else if (n_err.oversize) n_state = DROP;
    else                     n_state = RECV;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      acc_beats    <= '0;
      acc_bytes    <= '0;
      acc_sum      <= '0;
      acc_err      <= '0;
      first_id     <= '0;
      first_dest   <= '0;
      pkt_done     <= 1'b0;
      pkt_beats    <= '0;
      pkt_bytes    <= '0;
      pkt_checksum <= '0;
      pkt_id       <= '0;
      pkt_dest     <= '0;
      pkt_err      <= '0;
      pkt_count    <= '0;
    end else if (aclken) begin
      pkt_done <= 1'b0;
      if (accept) begin
        state      <= n_state;
        acc_beats  <= n_beats;
        acc_bytes  <= n_bytes;
        acc_sum    <= n_sum;
        acc_err    <= n_err;
        first_id   <= n_id;
        first_dest <= n_dest;
        if (s_axis.tlast) begin
          pkt_done     <= 1'b1;
          pkt_beats    <= n_beats;
          pkt_bytes    <= n_bytes;
          pkt_checksum <= n_sum;
          pkt_id       <= n_id;
          pkt_dest     <= n_dest;
          pkt_err      <= n_err;
          pkt_count    <= pkt_count + 32'd1;
        end
      end
    end
  end

`ifdef AXIS_SINK_PROTOCOL_CHECK_EN
  logic                         prev_stall;
  logic [C_AXIS_DATA_WIDTH-1:0] prev_data;
  logic [BYTES-1:0]             prev_keep;
  logic                         prev_last;
  logic [C_AXIS_ID_WIDTH-1:0]   prev_id;
  logic [C_AXIS_DEST_WIDTH-1:0] prev_dest;

  // A beat stalled last cycle must still be presented unchanged.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prev_stall <= 1'b0;
      prev_data  <= '0;
      prev_keep  <= '0;
      prev_last  <= 1'b0;
      prev_id    <= '0;
      prev_dest  <= '0;
      proto_err  <= 1'b0;
    end else if (aclken) begin
      prev_stall <= s_axis.tvalid & ~s_axis.tready;
      prev_data  <= s_axis.tdata;
      prev_keep  <= s_axis.tkeep;
      prev_last  <= s_axis.tlast;
      prev_id    <= s_axis.tid;
      prev_dest  <= s_axis.tdest;
      if (prev_stall && (!s_axis.tvalid || s_axis.tdata != prev_data ||
                         s_axis.tkeep != prev_keep || s_axis.tlast != prev_last ||
                         s_axis.tid != prev_id || s_axis.tdest != prev_dest))
        proto_err <= 1'b1;
    end
  end
`endif

endmodule
